// File: rtl/conv_pkg.sv
// Shared state encoding and arithmetic helpers for the streaming convolution blocks.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package conv_pkg;

  // Engine phases: load weights, collect a pixel, accumulate one output, present it.
  typedef enum logic [1:0] {
    LOADW  = 2'd0,
    GATHER = 2'd1,
    MAC    = 2'd2,
    EMIT   = 2'd3
  } conv_state_e;

  // Rounded/saturated result plus a flag telling whether the clamp fired.
  typedef struct packed {
    logic signed [63:0] val;
    logic               sat;
  } rsat_t;

  // Accumulator wide enough for C_IN full-precision signed products plus a bias word.
  function automatic int conv_acc_w(input int data_w, input int c_in);
    return 2 * data_w + $clog2(c_in) + 1;
  endfunction

  // Round half up, arithmetic shift right, then clamp to a signed out_w-bit range.
  function automatic rsat_t round_shift_sat(input logic signed [63:0] acc,
                                            input int                 shift,
                                            input int                 out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rsat_t              res;
    r = acc;
    if (shift > 0) begin
      r = r + (64'sd1 <<< (shift - 1));
    end
    r  = r >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    res.val = r;
    res.sat = 1'b0;
    if (r > hi) begin
      res.val = hi;
      res.sat = 1'b1;
    end else if (r < lo) begin
      res.val = lo;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate: acc = (init ? init_val : acc) + a*b when en is high.
// Latency: result registered one cycle after en; acc_nxt exposes the combinational next value.
// Backpressure: none; the caller gates en.
module conv_mac_unit #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init,
  input  logic                     en,
  input  logic signed [ACC_W-1:0]  init_val,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc_nxt
);

  logic signed [2*DATA_W-1:0] a_x;
  logic signed [2*DATA_W-1:0] b_x;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_x;
  logic signed [ACC_W-1:0]    base;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    acc_q;

  // Full-precision product, then add onto either the running sum or the seed value.
  always_comb begin
    a_x    = {{DATA_W{a[DATA_W-1]}}, a};
    b_x    = {{DATA_W{b[DATA_W-1]}}, b};
    prod   = a_x * b_x;
    prod_x = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
    base   = init ? init_val : acc_q;
    acc_d  = acc_q;
    if (en) begin
      acc_d = base + prod_x;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_nxt = acc_d;

endmodule

// File: rtl/conv_pointwise_2d_stream.sv
// Streaming 1x1 convolution: C_IN serial input beats per pixel -> C_OUT serial output beats.
// Latency: last input beat at t -> first out_valid at t+C_IN+1; each output handshake at e -> next at e+C_IN+1.
// Backpressure: out_valid/out_data held until out_ready; in_ready is low whenever a pixel is being computed.
module conv_pointwise_2d_stream #(
  parameter int DATA_W  = 8,
  parameter int C_IN    = 4,
  parameter int C_OUT   = 4,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 0,
  parameter int BIAS_EN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_valid,
  input  logic [DATA_W-1:0] w_data,
  output logic              w_done,
  input  logic              reload,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              out_sat
);
  import conv_pkg::*;

  localparam int ACC_W  = conv_acc_w(DATA_W, C_IN);
  localparam int NW     = C_IN * C_OUT;
  localparam int NWORDS = NW + ((BIAS_EN != 0) ? C_OUT : 0);
  localparam int WC_W   = $clog2(NWORDS + 1);
  localparam int CH_W   = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam int OC_W   = (C_OUT > 1) ? $clog2(C_OUT) : 1;
  localparam int WI_W   = (NW > 1) ? $clog2(NW) : 1;

  conv_state_e state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [OC_W-1:0]  oc_q, oc_d;
  logic             pend_q, pend_d;
  logic             w_done_q, w_done_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             out_sat_q, out_sat_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;

  // Weight, bias and pixel storage.
  logic [DATA_W-1:0] w_q    [NW];
  logic [DATA_W-1:0] bias_q [C_OUT];
  logic [DATA_W-1:0] px_q   [C_IN];
  logic              w_we, b_we, px_we;

  logic                     mac_init, mac_en;
  logic signed [DATA_W-1:0] mac_a, mac_b;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [63:0]       acc_ext;
  logic [WI_W-1:0]          widx;
  rsat_t                    rs;

  conv_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (mac_init),
    .en       (mac_en),
    .init_val (bias_ext),
    .a        (mac_a),
    .b        (mac_b),
    .acc_nxt  (acc_nxt)
  );

  // Select MAC operands for output channel oc_q, input channel ch_q; finish the result from the final sum.
  always_comb begin
    widx     = WI_W'(int'(oc_q) * C_IN + int'(ch_q));
    mac_a    = px_q[ch_q];
    mac_b    = w_q[widx];
    bias_ext = (BIAS_EN != 0) ? {{(ACC_W - DATA_W){bias_q[oc_q][DATA_W-1]}}, bias_q[oc_q]} : '0;
    acc_ext  = {{(64 - ACC_W){acc_nxt[ACC_W-1]}}, acc_nxt};
    rs       = round_shift_sat(acc_ext, SHIFT, OUT_W);
  end

  // Next-state and registered-output logic for the load/gather/mac/emit sequence.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    ch_d        = ch_q;
    oc_d        = oc_q;
    pend_d      = pend_q;
    w_done_d    = w_done_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;
    out_data_d  = out_data_q;
    w_we        = 1'b0;
    b_we        = 1'b0;
    px_we       = 1'b0;
    mac_init    = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      LOADW: begin
        w_done_d = 1'b0;
        pend_d   = 1'b0;
        if (reload) begin
          wcnt_d = '0;
        end else if (w_valid) begin
          if (wcnt_q < WC_W'(NW)) w_we = 1'b1;
          else                    b_we = 1'b1;
          if (wcnt_q == WC_W'(NWORDS - 1)) begin
            wcnt_d     = '0;
            w_done_d   = 1'b1;
            in_ready_d = 1'b1;
            state_d    = GATHER;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
      end
      GATHER: begin
        if (in_valid && in_ready_q) begin
          // A beat accepted alongside reload makes the pixel partial, so defer the reload.
          px_we = 1'b1;
          if (reload) pend_d = 1'b1;
          if (ch_q == CH_W'(C_IN - 1)) begin
            ch_d       = '0;
            oc_d       = '0;
            in_ready_d = 1'b0;
            state_d    = MAC;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else if (reload) begin
          if (ch_q == '0) begin
            state_d    = LOADW;
            w_done_d   = 1'b0;
            wcnt_d     = '0;
            in_ready_d = 1'b0;
            pend_d     = 1'b0;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      MAC: begin
        mac_en   = 1'b1;
        mac_init = (ch_q == '0);
        if (reload) pend_d = 1'b1;
        if (ch_q == CH_W'(C_IN - 1)) begin
          ch_d        = '0;
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_data_d  = OUT_W'(rs.val);
          out_sat_d   = rs.sat;
          out_last_d  = (oc_q == OC_W'(C_OUT - 1));
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      EMIT: begin
        if (reload) pend_d = 1'b1;
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          out_sat_d   = 1'b0;
          if (oc_q == OC_W'(C_OUT - 1)) begin
            oc_d = '0;
            if (pend_q || reload) begin
              state_d  = LOADW;
              w_done_d = 1'b0;
              wcnt_d   = '0;
              pend_d   = 1'b0;
            end else begin
              state_d    = GATHER;
              in_ready_d = 1'b1;
            end
          end else begin
            oc_d    = oc_q + OC_W'(1);
            state_d = MAC;
          end
        end
      end
      default: state_d = LOADW;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOADW;
      wcnt_q      <= '0;
      ch_q        <= '0;
      oc_q        <= '0;
      pend_q      <= 1'b0;
      w_done_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ch_q        <= ch_d;
      oc_q        <= oc_d;
      pend_q      <= pend_d;
      w_done_q    <= w_done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
      out_data_q  <= out_data_d;
    end
  end

  // Weight/bias/pixel register arrays; reset wipes the loaded weight set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NW; k++)    w_q[k]    <= '0;
      for (int k = 0; k < C_OUT; k++) bias_q[k] <= '0;
      for (int k = 0; k < C_IN; k++)  px_q[k]   <= '0;
    end else begin
      if (w_we)  w_q[WI_W'(wcnt_q)]                 <= w_data;
      if (b_we)  bias_q[OC_W'(wcnt_q - WC_W'(NW))]  <= w_data;
      if (px_we) px_q[ch_q]                         <= in_data;
    end
  end

  assign w_done    = w_done_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_conv_pointwise_2d_stream.sv
// Bench for conv_pointwise_2d_stream: two instances (SHIFT=0 and SHIFT=2, both with bias) share stimulus.
// Latency and stall behaviour are checked against cycle counts derived from C_IN.
// Expected outputs come from a real-arithmetic dot-product model.
`timescale 1ns/1ps
module tb_conv_pointwise_2d_stream;
  localparam int DW     = 8;
  localparam int CI     = 4;
  localparam int CO     = 2;
  localparam int OW     = 16;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_valid = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          reload = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          a_w_done, a_in_ready, a_out_valid, a_out_last, a_out_sat;
  logic [OW-1:0] a_out_data;
  logic          b_w_done, b_in_ready, b_out_valid, b_out_last, b_out_sat;
  logic [OW-1:0] b_out_data;

  conv_pointwise_2d_stream #(
    .DATA_W(DW), .C_IN(CI), .C_OUT(CO), .OUT_W(OW), .SHIFT(0), .BIAS_EN(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_data(w_data), .w_done(a_w_done),
    .reload(reload), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .out_sat(a_out_sat)
  );

  conv_pointwise_2d_stream #(
    .DATA_W(DW), .C_IN(CI), .C_OUT(CO), .OUT_W(OW), .SHIFT(2), .BIAS_EN(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_data(w_data), .w_done(b_w_done),
    .reload(reload), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .out_sat(b_out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int mw [CO][CI];
  int mb [CO];
  int mpx [CI];
  int exp_cyc = -1;
  int hs_cyc  = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Dot product plus bias, divided by 2^sh and rounded half up (before clamping).
  function automatic longint rounded(input int o, input int sh);
    longint acc;
    real    r;
    acc = mb[o];
    for (int i = 0; i < CI; i++) acc += longint'(mpx[i]) * longint'(mw[o][i]);
    r = real'(acc) / real'(longint'(1) << sh) + 0.5;
    return longint'($floor(r));
  endfunction

  function automatic longint clampv(input longint v);
    longint hi, lo;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic load_all();
    for (int o = 0; o < CO; o++)
      for (int i = 0; i < CI; i++) begin
        w_valid = 1'b1; w_data = DW'(mw[o][i]); @(negedge clk);
      end
    w_valid = 1'b0; @(negedge clk);
    for (int o = 0; o < CO; o++) begin
      w_valid = 1'b1; w_data = DW'(mb[o]); @(negedge clk);
    end
    w_valid = 1'b0;
    chk("w_done_a", a_w_done, 1);
    chk("w_done_b", b_w_done, 1);
    chk("in_ready_after_load", a_in_ready, 1);
  endtask

  task automatic rand_weights();
    for (int o = 0; o < CO; o++) begin
      for (int i = 0; i < CI; i++) mw[o][i] = int'($urandom_range(0, 255)) - 128;
      mb[o] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic rand_pixel();
    for (int i = 0; i < CI; i++) mpx[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d;
    while (!a_in_ready && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) chk("in_ready_timeout", a_in_ready, 1);
    hs_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_pixel(input int reload_after);
    for (int i = 0; i < CI; i++) begin
      if (i == reload_after) begin
        reload = 1'b1; @(negedge clk); reload = 1'b0;
      end
      send_beat(DW'(mpx[i]));
    end
    exp_cyc = hs_cyc + CI + 1;
  endtask

  task automatic recv_pixel(input int stall_o, input int stall_len);
    for (int o = 0; o < CO; o++) begin
      int n, st;
      longint va, vb;
      n  = 0;
      st = (o == stall_o) ? stall_len : 0;
      if (st == 0 && $urandom_range(0, 3) == 0) st = int'($urandom_range(1, 2));
      out_ready = (st == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      while (!a_out_valid && n < BUDGET) begin @(negedge clk); n++; end
      chk("out_valid_seen", a_out_valid, 1);
      if (exp_cyc >= 0) chk("latency", cyc, exp_cyc);
      va = rounded(o, 0);
      vb = rounded(o, 2);
      chk("a_data", $signed(a_out_data), clampv(va));
      chk("a_sat", a_out_sat, clampv(va) != va);
      chk("a_last", a_out_last, o == CO - 1);
      chk("b_valid", b_out_valid, 1);
      chk("b_data", $signed(b_out_data), clampv(vb));
      chk("b_sat", b_out_sat, clampv(vb) != vb);
      chk("b_last", b_out_last, o == CO - 1);
      chk("in_ready_emit", a_in_ready, 0);
      for (int k = 0; k < st; k++) begin
        @(negedge clk);
        chk("hold_valid", a_out_valid, 1);
        chk("hold_data", $signed(a_out_data), clampv(va));
        chk("hold_in_ready", a_in_ready, 0);
      end
      out_ready = 1'b1;
      exp_cyc = cyc + CI + 1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_drop", a_out_valid, 0);
    end
    exp_cyc = -1;
  endtask

  task automatic reload_idle();
    reload = 1'b1; @(negedge clk); reload = 1'b0;
    chk("reload_w_done", a_w_done, 0);
    chk("reload_in_ready", a_in_ready, 0);
  endtask

  initial begin
    // reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_w_done", a_w_done, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_in_ready_b", b_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_out_sat", a_out_sat, 0);
    chk("rst_out_data", a_out_data, 0);
    rst_n = 1'b1;

    // input beats are ignored while loading
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    chk("loadw_in_ready", a_in_ready, 0);
    chk("loadw_out_valid", a_out_valid, 0);
    in_valid = 1'b0;

    // basic dot product
    mw = '{'{1, 2, 3, 4}, '{-1, 0, 0, 1}};
    mb = '{0, 0};
    load_all();
    mpx = '{10, 20, 30, 40};
    send_pixel(-1);
    recv_pixel(-1, 0);

    // bias and round-half-up
    reload_idle();
    mw = '{'{1, 0, 0, 0}, '{-1, 0, 0, 0}};
    mb = '{2, 0};
    load_all();
    mpx = '{4, 0, 0, 0}; send_pixel(-1); recv_pixel(-1, 0);
    mpx = '{6, 0, 0, 0}; send_pixel(-1); recv_pixel(-1, 0);
    mpx = '{2, 0, 0, 0}; send_pixel(-1); recv_pixel(-1, 0);

    // saturation both directions
    reload_idle();
    mw = '{'{127, 127, 127, 127}, '{127, 127, 127, 127}};
    mb = '{0, 0};
    load_all();
    mpx = '{127, 127, 127, 127}; send_pixel(-1); recv_pixel(-1, 0);
    reload_idle();
    mw = '{'{-128, -128, -128, -128}, '{-128, -128, -128, -128}};
    load_all();
    send_pixel(-1); recv_pixel(-1, 0);

    // random weights, back-to-back pixels with a long stall
    reload_idle();
    rand_weights();
    load_all();
    rand_pixel(); send_pixel(-1); recv_pixel(0, 10);
    rand_pixel(); send_pixel(-1); recv_pixel(1, 10);
    rand_pixel(); send_pixel(-1); recv_pixel(-1, 0);

    // reload requested mid-pixel: current pixel finishes on old weights
    rand_pixel();
    send_pixel(2);
    recv_pixel(-1, 0);
    chk("pend_w_done", a_w_done, 0);
    chk("pend_in_ready", a_in_ready, 0);
    rand_weights();
    load_all();
    rand_pixel(); send_pixel(-1); recv_pixel(-1, 0);

    // reset during accumulation
    rand_pixel();
    send_pixel(-1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_w_done", a_w_done, 0);
    chk("mid_rst_in_ready", a_in_ready, 0);
    chk("mid_rst_out_valid", a_out_valid, 0);
    chk("mid_rst_out_data", a_out_data, 0);
    rst_n = 1'b1;
    exp_cyc = -1;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_in_ready", a_in_ready, 0);
    chk("post_rst_out_valid", a_out_valid, 0);
    in_valid = 1'b0;
    rand_weights();
    load_all();
    rand_pixel(); send_pixel(-1); recv_pixel(-1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_pointwise_2d_stream.md
Name: conv_pointwise_2d_stream

Overview:
- Parametrised streaming 1x1 (pointwise) convolution engine with runtime-loaded weights.
- Consumes one pixel as C_IN serial channel beats and emits C_OUT serial output beats.
- Uses a single time-multiplexed MAC, optional bias, rounding right-shift and saturation.
- Sits between the activation stream fabric and the next layer; valid/ready on both streams.

Parameters:
- DATA_W, 8: signed width of activations, weights and bias words.
- C_IN, 4: input channels per pixel (>=1).
- C_OUT, 4: output channels per pixel (>=1).
- OUT_W, 16: signed output width.
- SHIFT, 0: arithmetic right-shift applied to the accumulator before saturation.
- BIAS_EN, 0: 1 = C_OUT bias words follow the weights at load time.
- ACC_W, 2*DATA_W+$clog2(C_IN)+1: accumulator width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- w_valid  in  1  weight/bias word strobe.
- w_data  in  DATA_W  weight word, order w[o][i] with o-major, i-minor; then bias[o] if BIAS_EN.
- w_done  out  1  high once the full weight set is loaded.
- reload  in  1  pulse requesting a new weight set.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  DATA_W  channel i of the current pixel, i = 0..C_IN-1 in order.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_W  output channel o.
- out_last  out  1  high on the o = C_OUT-1 beat.
- out_sat  out  1  high when this beat was saturated.

Behaviour:
- One clock, reset synchronous active-low.
- Reset values: state=LOADW; all counters 0; pending-reload flag 0; w_done, in_ready, out_valid, out_last, out_sat = 0; out_data = 0.
- LOADW state:
  - Each w_valid stores one word; in_valid is ignored.
  - After C_IN*C_OUT (+C_OUT if BIAS_EN) words: w_done=1 and go to GATHER next cycle.
- GATHER state:
  - in_ready=1; accepted beats are stored in px[i].
  - On acceptance of beat C_IN-1: go to MAC with o=0.
- MAC state:
  - acc initialised to sign-extended bias[o] (0 if BIAS_EN=0).
  - Over C_IN cycles: acc += px[i]*w[o][i], full signed precision.
  - Then go to EMIT.
- EMIT state:
  - out_data = sat(round(acc)), registered; out_valid held with stable data until out_ready.
  - Rounding: if SHIFT>0, add 1<<(SHIFT-1), then arithmetic shift right by SHIFT (round half up).
  - Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 when the clamp fired.
  - On handshake: o<C_OUT-1 goes to MAC with o+1; o=C_OUT-1 goes to GATHER (or LOADW if reload is pending).
- Latency:
  - Last input beat accepted at cycle t gives out_valid at t+C_IN+1.
  - Output accepted at cycle e gives the next out_valid at e+C_IN+1.
  - Pixel period with no stalls: C_IN + C_OUT*(C_IN+1) cycles.
- in_ready=0 outside GATHER; out_valid=0 outside EMIT.
- reload handling:
  - In GATHER with channel count 0: go to LOADW next cycle, clear w_done and the word counter.
  - Elsewhere: set the pending flag; the reload is honoured at the end of the current pixel, and a partial pixel is never discarded.
  - reload in LOADW restarts the word counter.
- w_valid outside LOADW is ignored.
- Reset mid-operation: all state is discarded, including weights (w_done=0); a full reload is required.
- out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Shared package conv_pkg holds:
  - the state enum (LOADW, GATHER, MAC, EMIT);
  - the function computing ACC_W;
  - the round/shift/saturate function, reused by later conv blocks.
- One natural sub-module, conv_mac_unit: signed multiply-accumulate with init/enable, ACC_W parametrised.
- Weight/pixel storage stays as register arrays in the top level.

Test Plan:
- Basic result (DATA_W=8, C_IN=4, C_OUT=2, SHIFT=0, OUT_W=16):
  - Stimulus: weights o0=[1,2,3,4], o1=[-1,0,0,1]; pixel [10,20,30,40].
  - Required: out 300 then 30 with out_last on the second beat; first out_valid exactly 5 cycles after the last input handshake.
- Bias and rounding (BIAS_EN=1, SHIFT=2):
  - Stimulus: weights o0=[1,0,0,0] bias 2 with pixel 4; and o1=[-1,0,0,0] bias 0 with pixel 6.
  - Required: 6 -> out 2; -6 -> out -1.
- Saturation (OUT_W=16):
  - Stimulus: all weights 127, pixel [127,127,127,127] (sum 64516); then all weights -128, pixel 127.
  - Required: out 32767 with out_sat=1; then out -32768 with out_sat=1.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles during EMIT.
  - Required: out_data stable, in_ready=0 throughout, no beat lost or duplicated; 3 back-to-back pixels give 6 correct outputs.
- Reload:
  - Stimulus: reload pulse after 2 input beats.
  - Required: current pixel completes with the old weights; then w_done=0 and LOADW; the next pixel uses the new weights.
- Reset mid-MAC:
  - Stimulus: rst_n low for 1 cycle during MAC.
  - Required: all outputs at reset values next cycle; in_valid ignored until the weights are reloaded.
